// File: rtl/int_array_fork2.sv
// -----------------------------------------------------------------------------
// int_array_fork2
//   Broadcasts one signed integer array stream to two independent consumers.
//   Every accepted beat is written into both branch FIFOs in the same cycle.
//   Each branch drains on its own handshake, so a stalled consumer only
//   back-pressures the producer once its own FIFO is full.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   data_in[DIM_0]            signed input array beat
//   valid_in / ready_in       input handshake (ready_in from registered counts)
//   data_out_a / data_out_b   head entry of FIFO A / B (show-ahead, 0 when empty)
//   valid_out_a / valid_out_b branch has at least one queued beat
//   ready_out_a / ready_out_b branch consumer ready
//   stall_cnt_a / stall_cnt_b 32-bit saturating stall counters, only present
//                             when INT_ARRAY_FORK2_STALL_CNT_EN is defined
//
// Optional feature macro: INT_ARRAY_FORK2_STALL_CNT_EN
// -----------------------------------------------------------------------------
module int_array_fork2 #(
    parameter int DATA_WIDTH   = 8,
    parameter int DIM_0        = 8,
    parameter int BRANCH_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] data_in     [DIM_0],
    input  logic                         valid_in,
    output logic                         ready_in,
    output logic signed [DATA_WIDTH-1:0] data_out_a  [DIM_0],
    output logic                         valid_out_a,
    input  logic                         ready_out_a,
    output logic signed [DATA_WIDTH-1:0] data_out_b  [DIM_0],
    output logic                         valid_out_b,
    input  logic                         ready_out_b
`ifdef INT_ARRAY_FORK2_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cnt_a,
    output logic [31:0]                  stall_cnt_b
`endif
);

    localparam int FLAT_W = DATA_WIDTH * DIM_0;
    localparam int PTR_W  = $clog2(BRANCH_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BRANCH_DEPTH);

    // Branch storage is not reset: an entry is only observable while its
    // branch count covers it, and outputs are forced to zero when empty.
    logic [FLAT_W-1:0] mem_a_q [BRANCH_DEPTH];
    logic [FLAT_W-1:0] mem_b_q [BRANCH_DEPTH];

    // Both FIFOs are always written together, so one tail pointer serves both.
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_a_q, rd_ptr_a_d;
    logic [PTR_W-1:0] rd_ptr_b_q, rd_ptr_b_d;
    logic [CNT_W-1:0] cnt_a_q,    cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q,    cnt_b_d;

    logic [FLAT_W-1:0] flat_in;
    logic [FLAT_W-1:0] head_a;
    logic [FLAT_W-1:0] head_b;
    logic              push;
    logic              pop_a;
    logic              pop_b;

    always_comb begin
        flat_in = '0;
        for (int i = 0; i < DIM_0; i++) begin
            flat_in[i*DATA_WIDTH +: DATA_WIDTH] = data_in[i];
        end
    end

    // ready_in depends only on registered counts, never on the consumers.
    assign ready_in    = (cnt_a_q != CNT_FULL) && (cnt_b_q != CNT_FULL);
    assign valid_out_a = (cnt_a_q != '0);
    assign valid_out_b = (cnt_b_q != '0);

    assign push  = valid_in && ready_in;
    assign pop_a = valid_out_a && ready_out_a;
    assign pop_b = valid_out_b && ready_out_b;

    assign head_a = mem_a_q[rd_ptr_a_q];
    assign head_b = mem_b_q[rd_ptr_b_q];

    always_comb begin
        for (int i = 0; i < DIM_0; i++) begin
            data_out_a[i] = valid_out_a ? head_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            data_out_b[i] = valid_out_b ? head_b[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    // Pointers wrap naturally because BRANCH_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_a_d = rd_ptr_a_q;
        rd_ptr_b_d = rd_ptr_b_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;

        if (push)  wr_ptr_d   = wr_ptr_q + PTR_ONE;
        if (pop_a) rd_ptr_a_d = rd_ptr_a_q + PTR_ONE;
        if (pop_b) rd_ptr_b_d = rd_ptr_b_q + PTR_ONE;

        if (push && !pop_a)      cnt_a_d = cnt_a_q + CNT_ONE;
        else if (!push && pop_a) cnt_a_d = cnt_a_q - CNT_ONE;

        if (push && !pop_b)      cnt_b_d = cnt_b_q + CNT_ONE;
        else if (!push && pop_b) cnt_b_d = cnt_b_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_a_q <= '0;
            rd_ptr_b_q <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_a_q <= rd_ptr_a_d;
            rd_ptr_b_q <= rd_ptr_b_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
        end
    end

    // A write during reset is harmless: the cleared counts hide it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= flat_in;
            mem_b_q[wr_ptr_q] <= flat_in;
        end
    end

`ifdef INT_ARRAY_FORK2_STALL_CNT_EN
    logic [31:0] stall_a_q, stall_a_d;
    logic [31:0] stall_b_q, stall_b_d;

    // Saturating: once all ones, the counter holds until reset.
    always_comb begin
        stall_a_d = stall_a_q;
        stall_b_d = stall_b_q;
        if (valid_out_a && !ready_out_a && (stall_a_q != 32'hFFFF_FFFF))
            stall_a_d = stall_a_q + 32'd1;
        if (valid_out_b && !ready_out_b && (stall_b_q != 32'hFFFF_FFFF))
            stall_b_d = stall_b_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_a_q <= '0;
            stall_b_q <= '0;
        end else begin
            stall_a_q <= stall_a_d;
            stall_b_q <= stall_b_d;
        end
    end

    assign stall_cnt_a = stall_a_q;
    assign stall_cnt_b = stall_b_q;
`endif

endmodule

// File: tb/tb_int_array_fork2.sv
module tb_int_array_fork2;

    localparam int W = 8;
    localparam int N = 8;
    localparam int D = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] din    [N];
    logic                valid_in;
    logic                ready_in;
    logic signed [W-1:0] dout_a [N];
    logic                valid_out_a;
    logic                ready_out_a;
    logic signed [W-1:0] dout_b [N];
    logic                valid_out_b;
    logic                ready_out_b;
`ifdef INT_ARRAY_FORK2_STALL_CNT_EN
    logic [31:0]         stall_cnt_a;
    logic [31:0]         stall_cnt_b;
`endif

    int total = 0;
    int bad   = 0;

    int_array_fork2 #(.DATA_WIDTH(W), .DIM_0(N), .BRANCH_DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (din),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_out_a  (dout_a),
        .valid_out_a (valid_out_a),
        .ready_out_a (ready_out_a),
        .data_out_b  (dout_b),
        .valid_out_b (valid_out_b),
        .ready_out_b (ready_out_b)
`ifdef INT_ARRAY_FORK2_STALL_CNT_EN
        ,
        .stall_cnt_a (stall_cnt_a),
        .stall_cnt_b (stall_cnt_b)
`endif
    );

    always #5 clk = ~clk;

    logic [W*N-1:0] fa, fb;
    always_comb begin
        fa = '0;
        fb = '0;
        for (int i = 0; i < N; i++) begin
            fa[i*W +: W] = dout_a[i];
            fb[i*W +: W] = dout_b[i];
        end
    end

    // Beat contents derived from a seed; upper elements wrap negative.
    function automatic logic [W*N-1:0] pack(input int seed);
        logic [W*N-1:0] r;
        r = '0;
        if (seed != 0)
            for (int i = 0; i < N; i++) r[i*W +: W] = W'(seed + i * 32);
        return r;
    endfunction

    task automatic set_din(input int seed);
        for (int i = 0; i < N; i++) din[i] = W'(seed + i * 32);
    endtask

    task automatic chk(input string nm, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic vin;
        int   seed;
        logic ra;
        logic rb;
        logic exp_va;
        int   exp_sa;
        logic exp_vb;
        int   exp_sb;
        logic exp_rin;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic vin, input int seed, input logic ra, input logic rb,
                                input logic va, input int sa, input logic vb, input int sb,
                                input logic rin);
        vec_t v;
        v.vin = vin; v.seed = seed; v.ra = ra; v.rb = rb;
        v.exp_va = va; v.exp_sa = sa; v.exp_vb = vb; v.exp_sb = sb; v.exp_rin = rin;
        return v;
    endfunction

    int qa[$];
    int qb[$];

    initial begin
        rst = 1'b0; valid_in = 1'b0; ready_out_a = 1'b1; ready_out_b = 1'b1;
        set_din(0);

        // Streaming with both consumers ready: 1-cycle latency, no back-pressure.
        for (int k = 1; k <= 8; k++) vt.push_back(mk(1, k, 1, 1, 1, k, 1, k, 1));
        vt.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1));
        // Branch B stalled: A drains, B fills and blocks the producer.
        vt.push_back(mk(1, 11, 1, 0, 1, 11, 1, 11, 1));
        vt.push_back(mk(1, 12, 1, 0, 1, 12, 1, 11, 1));
        vt.push_back(mk(1, 13, 1, 0, 1, 13, 1, 11, 1));
        vt.push_back(mk(1, 14, 1, 0, 1, 14, 1, 11, 0));
        vt.push_back(mk(1, 15, 1, 0, 0, 0,  1, 11, 0));
        vt.push_back(mk(1, 15, 1, 0, 0, 0,  1, 11, 0));
        vt.push_back(mk(1, 15, 1, 1, 0, 0,  1, 12, 1));
        vt.push_back(mk(1, 15, 1, 1, 1, 15, 1, 13, 1));
        vt.push_back(mk(1, 16, 1, 1, 1, 16, 1, 14, 1));
        vt.push_back(mk(0, 0,  1, 1, 0, 0,  1, 15, 1));
        vt.push_back(mk(0, 0,  1, 1, 0, 0,  1, 16, 1));
        vt.push_back(mk(0, 0,  1, 1, 0, 0,  0, 0,  1));
        // Both at count 3, then push with only A popping.
        vt.push_back(mk(1, 21, 0, 0, 1, 21, 1, 21, 1));
        vt.push_back(mk(1, 22, 0, 0, 1, 21, 1, 21, 1));
        vt.push_back(mk(1, 23, 0, 0, 1, 21, 1, 21, 1));
        vt.push_back(mk(1, 24, 1, 0, 1, 22, 1, 21, 0));
        vt.push_back(mk(0, 0,  1, 1, 1, 23, 1, 22, 1));
        vt.push_back(mk(0, 0,  1, 1, 1, 24, 1, 23, 1));
        vt.push_back(mk(0, 0,  1, 1, 0, 0,  1, 24, 1));
        vt.push_back(mk(0, 0,  1, 1, 0, 0,  0, 0,  1));

        repeat (2) @(posedge clk);
        #1;
        chk("rst valid_a", 64'(valid_out_a), 64'(0));
        chk("rst valid_b", 64'(valid_out_b), 64'(0));
        chk("rst ready_in", 64'(ready_in), 64'(1));
        chk("rst data_a", fa, '0);
        chk("rst data_b", fb, '0);
        rst = 1'b1;

        foreach (vt[k]) begin
            valid_in = vt[k].vin; set_din(vt[k].seed);
            ready_out_a = vt[k].ra; ready_out_b = vt[k].rb;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d valid_a", k), 64'(valid_out_a), 64'(vt[k].exp_va));
            chk($sformatf("vec%0d data_a", k), fa, pack(vt[k].exp_sa));
            chk($sformatf("vec%0d valid_b", k), 64'(valid_out_b), 64'(vt[k].exp_vb));
            chk($sformatf("vec%0d data_b", k), fb, pack(vt[k].exp_sb));
            chk($sformatf("vec%0d ready_in", k), 64'(ready_in), 64'(vt[k].exp_rin));
        end

        // Random per-branch readiness against a queue model.
        begin
            int pushed = 0;
            int popped_a = 0;
            int popped_b = 0;
            int cyc = 0;
            while ((pushed < 20 || qa.size() != 0 || qb.size() != 0) && cyc < 2000) begin
                ready_out_a = 1'($urandom_range(0, 1));
                ready_out_b = 1'($urandom_range(0, 1));
                valid_in = (pushed < 20) ? ($urandom_range(0, 3) != 0) : 1'b0;
                set_din(31 + pushed);
                #1;
                chk("rnd valid_a", 64'(valid_out_a), 64'(qa.size() != 0));
                chk("rnd valid_b", 64'(valid_out_b), 64'(qb.size() != 0));
                chk("rnd ready_in", 64'(ready_in), 64'(qa.size() < D && qb.size() < D));
                if (qa.size() != 0) chk("rnd data_a", fa, pack(qa[0]));
                if (qb.size() != 0) chk("rnd data_b", fb, pack(qb[0]));
                if (qa.size() != 0 && ready_out_a) begin void'(qa.pop_front()); popped_a++; end
                if (qb.size() != 0 && ready_out_b) begin void'(qb.pop_front()); popped_b++; end
                if (valid_in && qa.size() + (ready_out_a && popped_a > 0 ? 0 : 0) >= 0
                    && ready_in) begin
                    qa.push_back(31 + pushed);
                    qb.push_back(31 + pushed);
                    pushed++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("rnd timeout", 64'(cyc < 2000), 64'(1));
            chk("rnd count_a", 64'(popped_a), 64'(20));
            chk("rnd count_b", 64'(popped_b), 64'(20));
        end

        // Mid-operation reset with a beat offered in the reset cycle.
        ready_out_a = 1'b0; ready_out_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_in = 1'b1; set_din(70 + k);
            @(posedge clk);
            #1;
        end
        chk("pre-rst valid_a", 64'(valid_out_a), 64'(1));
        rst = 1'b0; valid_in = 1'b1; set_din(80);
        @(posedge clk);
        #1;
        rst = 1'b1; valid_in = 1'b0; ready_out_a = 1'b1; ready_out_b = 1'b1;
        chk("mid-rst valid_a", 64'(valid_out_a), 64'(0));
        chk("mid-rst valid_b", 64'(valid_out_b), 64'(0));
        chk("mid-rst ready_in", 64'(ready_in), 64'(1));
        chk("mid-rst data_a", fa, '0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post-rst valid_a", 64'(valid_out_a), 64'(0));
            chk("post-rst valid_b", 64'(valid_out_b), 64'(0));
        end

`ifdef INT_ARRAY_FORK2_STALL_CNT_EN
        // One beat held on A for 7 cycles while B drains it at once.
        chk("stall init a", 64'(stall_cnt_a), 64'(0));
        valid_in = 1'b1; set_din(90); ready_out_a = 1'b0; ready_out_b = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        chk("stall_cnt_a", 64'(stall_cnt_a), 64'(7));
        chk("stall_cnt_b", 64'(stall_cnt_b), 64'(0));
        chk("stall hold data_a", fa, pack(90));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
